frame_serializer: RTL and testbench

//   Transmit side of the ping-pong frame interface: accepts parallel sample words over valid/ready,

---
 rtl/ser_pkg.sv | 15 +
 rtl/frame_serializer_counter.sv | 22 ++
 rtl/frame_serializer.sv | 124 ++++++++++++
 tb/tb_frame_serializer.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/ser_pkg.sv
// Shared types for the ping-pong frame serializer/deserializer pair.
package ser_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    SWITCH = 2'd2
  } ser_state_t;

  // Counter width for a modulus n, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/frame_serializer_counter.sv
// Free-running modulo-MAX_COUNT counter, advancing only while en is high.
module frame_serializer_counter
  import ser_pkg::*;
#(
  parameter  int unsigned MAX_COUNT = 512,
  localparam int unsigned CW        = cnt_w(MAX_COUNT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic [CW-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (en) begin
      count <= (count == CW'(MAX_COUNT - 1)) ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/frame_serializer.sv
// Word-to-bit serializer driving a ping-pong buffer: continuous MSB-first stream
// with a one-cycle switch strobe between frames of FRAME_BITS bits.
module frame_serializer
  import ser_pkg::*;
#(
  parameter int unsigned FRAME_BITS = 512,
  parameter int unsigned WORD_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [WORD_W-1:0] s_data,
  output logic              bit_out,
  output logic              switch,
  output logic              frame_done,
  output logic              underrun
);

  localparam int unsigned FCW = cnt_w(FRAME_BITS);
  localparam int unsigned WCW = cnt_w(WORD_W);

  if ((FRAME_BITS % WORD_W) != 0) begin : g_bad_cfg
    $error("frame_serializer: FRAME_BITS must be a multiple of WORD_W");
  end

  ser_state_t        state;
  logic [WORD_W-1:0] hold;
  logic              hold_vld;
  logic [WORD_W-1:0] shreg;
  logic [WCW-1:0]    wcnt;
  logic [FCW-1:0]    fcnt;

  logic accept_c;
  logic run_c;
  logic word_last_c;
  logic frame_last_c;

  assign s_ready      = ~hold_vld;
  assign accept_c     = s_valid & ~hold_vld;
  assign run_c        = (state == RUN);
  assign word_last_c  = (wcnt == WCW'(WORD_W - 1));
  assign frame_last_c = (fcnt == FCW'(FRAME_BITS - 1));

  frame_serializer_counter #(
    .MAX_COUNT (FRAME_BITS)
  ) u_fcnt (
    .clk   (clk),
    .rst   (rst),
    .en    (run_c),
    .count (fcnt)
  );

  // The word for the next frame is pulled from hold only once the frame boundary
  // is committed (SWITCH with en, or IDLE start), so a held word is never lost to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      switch     <= 1'b1;
      bit_out    <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
      hold       <= '0;
      hold_vld   <= 1'b0;
      shreg      <= '0;
      wcnt       <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          switch  <= 1'b1;
          bit_out <= 1'b0;
          if (en && hold_vld) begin
            shreg    <= hold;
            hold_vld <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          switch  <= 1'b0;
          bit_out <= shreg[WORD_W-1];
          shreg   <= shreg << 1;
          wcnt    <= word_last_c ? '0 : wcnt + WCW'(1);
          if (frame_last_c) begin
            state <= SWITCH;
          end else if (word_last_c) begin
            if (hold_vld) begin
              shreg    <= hold;
              hold_vld <= 1'b0;
            end else begin
              shreg    <= '0;
              underrun <= 1'b1;
            end
          end
        end
        SWITCH: begin
          switch     <= 1'b1;
          frame_done <= 1'b1;
          if (en) begin
            state <= RUN;
            if (hold_vld) begin
              shreg    <= hold;
              hold_vld <= 1'b0;
            end else begin
              shreg    <= '0;
              underrun <= 1'b1;
            end
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
      if (accept_c) begin
        hold     <= s_data;
        hold_vld <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_frame_serializer.sv
// Directed bench for frame_serializer with FRAME_BITS=32, WORD_W=8.
module tb_frame_serializer;

  localparam int unsigned FB = 32;
  localparam int unsigned WW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          s_valid;
  logic          s_ready;
  logic [WW-1:0] s_data;
  logic          bit_out;
  logic          switch;
  logic          frame_done;
  logic          underrun;

  int            n_vec = 0;
  int            n_err = 0;
  logic [WW-1:0] q[$];
  bit            feed_en = 1'b1;

  always #5 clk = ~clk;

  frame_serializer #(
    .FRAME_BITS (FB),
    .WORD_W     (WW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .bit_out    (bit_out),
    .switch     (switch),
    .frame_done (frame_done),
    .underrun   (underrun)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: retire the word offered last cycle, then offer the next one at negedge.
  task automatic nxt();
    @(posedge clk);
    if (s_valid) void'(q.pop_front());
    @(negedge clk);
    if (feed_en && s_ready && q.size() > 0) begin
      s_valid = 1'b1;
      s_data  = q[0];
    end else begin
      s_valid = 1'b0;
    end
  endtask

  task automatic push_frame(input logic [31:0] f);
    for (int k = 0; k < 4; k++) q.push_back(f[31-8*k -: 8]);
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    while (switch !== 1'b0 && n < 12) begin
      nxt();
      n++;
    end
    chk($sformatf("%s_start", tag), 32'(switch), 32'd0);
  endtask

  task automatic check_frame(input string tag, input logic [31:0] exp,
                             input int starve_at, input int resume_at, input int drop_en_at);
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("%s_bit%0d", tag, i), 32'(bit_out), 32'(exp[31-i]));
      chk($sformatf("%s_sw%0d", tag, i), 32'(switch), 32'd0);
      if (i == starve_at)  feed_en = 1'b0;
      if (i == resume_at)  feed_en = 1'b1;
      if (i == drop_en_at) en = 1'b0;
      nxt();
    end
    chk($sformatf("%s_switch", tag), 32'(switch), 32'd1);
    chk($sformatf("%s_done", tag), 32'(frame_done), 32'd1);
  endtask

  initial begin
    rst     = 1'b1;
    en      = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    #1;
    chk("rst_switch", 32'(switch), 32'd1);
    chk("rst_bit", 32'(bit_out), 32'd0);
    chk("rst_ready", 32'(s_ready), 32'd1);
    chk("rst_underrun", 32'(underrun), 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    push_frame(32'hA53CFF01);
    push_frame(32'h12345678);
    push_frame(32'hDEADBEEF);
    push_frame(32'hC0FFEE11);
    push_frame(32'h11220044);
    void'(q.pop_back());
    void'(q.pop_back());
    q.push_back(8'h44);
    push_frame(32'h55667788);
    en = 1'b1;

    // First frame, then three more back-to-back.
    wait_start("f1");
    check_frame("f1", 32'hA53CFF01, -1, -1, -1);
    nxt();
    check_frame("f2", 32'h12345678, -1, -1, -1);
    nxt();
    check_frame("f3", 32'hDEADBEEF, -1, -1, -1);
    nxt();
    check_frame("f4", 32'hC0FFEE11, -1, -1, -1);
    chk("f4_no_underrun", 32'(underrun), 32'd0);

    // Third word withheld: slot zero-padded, sticky underrun.
    nxt();
    check_frame("f5", 32'h11220044, 0, 15, -1);
    chk("f5_underrun", 32'(underrun), 32'd1);

    // en dropped mid-frame: frame completes, then IDLE.
    nxt();
    check_frame("f6", 32'h55667788, -1, -1, 10);
    for (int c = 0; c < 3; c++) begin
      nxt();
      chk($sformatf("idle_switch%0d", c), 32'(switch), 32'd1);
      chk($sformatf("idle_bit%0d", c), 32'(bit_out), 32'd0);
      chk($sformatf("idle_done%0d", c), 32'(frame_done), 32'd0);
    end
    chk("idle_underrun", 32'(underrun), 32'd1);
    chk("idle_ready", 32'(s_ready), 32'd1);

    q.push_back(8'h80);
    en = 1'b1;
    wait_start("restart");
    chk("restart_bit0", 32'(bit_out), 32'd1);

    // Async reset mid-frame with a word held.
    q.push_back(8'h99);
    repeat (3) nxt();
    chk("pre_rst_ready", 32'(s_ready), 32'd0);
    chk("pre_rst_switch", 32'(switch), 32'd0);
    s_valid = 1'b0;
    rst     = 1'b1;
    #1;
    chk("arst_switch", 32'(switch), 32'd1);
    chk("arst_bit", 32'(bit_out), 32'd0);
    chk("arst_ready", 32'(s_ready), 32'd1);
    chk("arst_underrun", 32'(underrun), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    nxt();
    nxt();
    chk("post_rst_switch", 32'(switch), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
